// File: rtl/dcbus_pkg.sv
// Shared types and constants for the D-cache miss bus master.
// State encodings, beat-count helper and response codes.
package dcbus_pkg;

  typedef logic [1:0] ws_t;
  typedef logic [1:0] rs_t;

  localparam ws_t WS_IDLE = 2'd0;
  localparam ws_t WS_ADDR = 2'd1;
  localparam ws_t WS_DATA = 2'd2;
  localparam ws_t WS_RESP = 2'd3;

  localparam rs_t RS_IDLE = 2'd0;
  localparam rs_t RS_ADDR = 2'd1;
  localparam rs_t RS_DATA = 2'd2;
  localparam rs_t RS_DLVR = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int beats(input int dw);
    return 128 / dw;
  endfunction

endpackage

// File: rtl/dcbus_if.sv
// Memory-side bus of the D-cache miss master.
// Write address/data/response and read address/data channels.
interface dcbus_if #(
  parameter int BUS_DW = 32
) ();

  logic              awvalid;
  logic              awready;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic              wvalid;
  logic              wready;
  logic [BUS_DW-1:0] wdata;
  logic [BUS_DW/8-1:0] wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic [BUS_DW-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arlen,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arlen,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/dcbus_rd_assemble.sv
// Refill beat counter and line register.
// Packs BUS_DW-wide beats into a 128-bit line, lowest beat first.
module dcbus_rd_assemble
  import dcbus_pkg::*;
#(
  parameter int BUS_DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_DW-1:0] beat,
  input  logic              en,
  input  logic              clr,
  output logic [127:0]      line,
  output logic              last_beat
);

  localparam int BEATS = beats(BUS_DW);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0] cnt;

  assign last_beat = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      line <= '0;
    end else if (clr) begin
      cnt  <= '0;
      line <= '0;
    end else if (en) begin
      line[int'(cnt)*BUS_DW +: BUS_DW] <= beat;
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dc_bus_master.sv
// D-cache miss bus master: write-back and refill channels to memory.
// Optional watchdog abort enabled by defining DCBUS_TIMEOUT_EN.
module dc_bus_master
  import dcbus_pkg::*;
#(
  parameter int BUS_DW = 32,
  parameter int TO_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  input  logic         rqfull_1,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic         bus_err,
  dcbus_if.master      bus
);

  localparam int BEATS = beats(BUS_DW);
  localparam int SW = BUS_DW / 8;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  ws_t           ws;
  rs_t           rs;
  logic          awvalid, wvalid, wlast, bready;
  logic [31:0]   awaddr;
  logic [127:0]  wline;
  logic [15:0]   wstrb_q;
  logic [CW-1:0] wcnt;
  logic          arvalid, rready, rd_pend, dlv_ph;
  logic [31:0]   araddr;
  logic [127:0]  line;
  logic          last_beat;
  logic          w_to, r_to;
  logic          w_err, r_err, wr_free;
  logic          unused_ok;

  assign unused_ok = ^{dcw_in_addr[3:0], dcr_rin_addr[3:0], 1'(TO_CYC)};

  assign bus.awvalid = awvalid;
  assign bus.awaddr  = awaddr;
  assign bus.awlen   = 8'(BEATS - 1);
  assign bus.wvalid  = wvalid;
  assign bus.wdata   = wline[BUS_DW-1:0];
  assign bus.wstrb   = wstrb_q[SW-1:0];
  assign bus.wlast   = wlast;
  assign bus.bready  = bready;
  assign bus.arvalid = arvalid;
  assign bus.araddr  = araddr;
  assign bus.arlen   = 8'(BEATS - 1);
  assign bus.rready  = rready;

  // A pending refill may go once the write is idle or retiring this edge.
  assign wr_free = (ws == WS_IDLE) || (bready && bus.bvalid);

`ifdef DCBUS_TIMEOUT_EN
  localparam int TB = $clog2(TO_CYC + 1);
  localparam int TW = (TB > 8) ? TB : 8;

  logic [TW-1:0] wto_cnt, rto_cnt;
  logic          w_wait, r_wait;

  assign w_wait = (awvalid && !bus.awready)
               || (wvalid && !bus.wready)
               || (bready && !bus.bvalid);
  assign r_wait = (arvalid && !bus.arready)
               || (rready && !bus.rvalid);
  assign w_to = w_wait && (wto_cnt == TW'(TO_CYC - 1));
  assign r_to = r_wait && (rto_cnt == TW'(TO_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wto_cnt <= '0;
      rto_cnt <= '0;
    end else begin
      wto_cnt <= (w_wait && !w_to) ? wto_cnt + 1'b1 : '0;
      rto_cnt <= (r_wait && !r_to) ? rto_cnt + 1'b1 : '0;
    end
  end
`else
  assign w_to = 1'b0;
  assign r_to = 1'b0;
`endif

  assign w_err = (dcw_start_rq && ws != WS_IDLE)
              || (bready && bus.bvalid && bus.bresp != RESP_OKAY)
              || w_to;
  assign r_err = (dcr_start_rq && rs != RS_IDLE)
              || (rready && bus.rvalid
                  && (bus.rresp != RESP_OKAY
                      || bus.rlast != last_beat))
              || r_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err <= 1'b0;
    else if (w_err || r_err) bus_err <= 1'b1;
  end

  // Data and strobes shift down one beat per transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws <= WS_IDLE;
      awvalid <= 1'b0;
      awaddr <= '0;
      wvalid <= 1'b0;
      wlast <= 1'b0;
      bready <= 1'b0;
      wline <= '0;
      wstrb_q <= '0;
      wcnt <= '0;
      dcw_finish_wresp <= 1'b0;
    end else begin
      dcw_finish_wresp <= 1'b0;
      if (w_to) begin
        ws <= WS_IDLE;
        awvalid <= 1'b0;
        wvalid <= 1'b0;
        wlast <= 1'b0;
        bready <= 1'b0;
        dcw_finish_wresp <= 1'b1;
      end else begin
        unique case (ws)
          WS_IDLE: if (dcw_start_rq) begin
            ws <= WS_ADDR;
            awaddr <= {dcw_in_addr[31:4], 4'h0};
            wline <= dcw_in_data;
            wstrb_q <= ~dcw_in_mask;
            awvalid <= 1'b1;
          end
          WS_ADDR: if (bus.awready) begin
            ws <= WS_DATA;
            awvalid <= 1'b0;
            wvalid <= 1'b1;
            wcnt <= '0;
            wlast <= (LAST == '0);
          end
          WS_DATA: if (bus.wready) begin
            if (wcnt == LAST) begin
              ws <= WS_RESP;
              wvalid <= 1'b0;
              wlast <= 1'b0;
              bready <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
              wlast <= (wcnt + 1'b1 == LAST);
              wline <= wline >> BUS_DW;
              wstrb_q <= wstrb_q >> SW;
            end
          end
          WS_RESP: if (bus.bvalid) begin
            ws <= WS_IDLE;
            bready <= 1'b0;
            dcw_finish_wresp <= 1'b1;
          end
          default: ws <= WS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs <= RS_IDLE;
      arvalid <= 1'b0;
      araddr <= '0;
      rready <= 1'b0;
      rd_pend <= 1'b0;
      dlv_ph <= 1'b0;
      rdat_m_valid <= 1'b0;
      rdat_m_data <= '0;
      finish_mrd <= 1'b0;
    end else begin
      rdat_m_valid <= 1'b0;
      finish_mrd <= 1'b0;
      if (r_to) begin
        rs <= RS_DLVR;
        arvalid <= 1'b0;
        rready <= 1'b0;
      end else begin
        unique case (rs)
          RS_IDLE: if (dcr_start_rq) begin
            rs <= RS_ADDR;
            araddr <= {dcr_rin_addr[31:4], 4'h0};
            if (ws != WS_IDLE || dcw_start_rq) rd_pend <= 1'b1;
            else arvalid <= 1'b1;
          end
          RS_ADDR: if (rd_pend) begin
            if (wr_free) begin
              rd_pend <= 1'b0;
              arvalid <= 1'b1;
            end
          end else if (bus.arready) begin
            rs <= RS_DATA;
            arvalid <= 1'b0;
            rready <= 1'b1;
          end
          RS_DATA: if (bus.rvalid && last_beat) begin
            rs <= RS_DLVR;
            rready <= 1'b0;
          end
          RS_DLVR: if (dlv_ph) begin
            rs <= RS_IDLE;
            dlv_ph <= 1'b0;
            finish_mrd <= 1'b1;
          end else if (!rqfull_1) begin
            dlv_ph <= 1'b1;
            rdat_m_valid <= 1'b1;
            rdat_m_data <= line;
          end
          default: rs <= RS_IDLE;
        endcase
      end
    end
  end

  dcbus_rd_assemble #(
    .BUS_DW(BUS_DW)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .beat      (bus.rdata),
    .en        (rready && bus.rvalid),
    .clr       (arvalid && bus.arready),
    .line      (line),
    .last_beat (last_beat)
  );

endmodule

// File: tb/tb_dc_bus_master.sv
// Directed bench for dc_bus_master, BUS_DW = 32.
// Vector tables for write/refill plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_dc_bus_master;
  import dcbus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dcw_start_rq = 1'b0;
  logic [31:0] dcw_in_addr = '0;
  logic [15:0] dcw_in_mask = '0;
  logic [127:0] dcw_in_data = '0;
  logic dcw_finish_wresp;
  logic dcr_start_rq = 1'b0;
  logic [31:0] dcr_rin_addr = '0;
  logic rqfull_1 = 1'b0;
  logic [127:0] rdat_m_data;
  logic rdat_m_valid;
  logic finish_mrd;
  logic bus_err;

  always #5 clk = ~clk;

  dcbus_if #(.BUS_DW(32)) bus ();

  dc_bus_master #(
    .BUS_DW(32),
    .TO_CYC(16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dcw_start_rq     (dcw_start_rq),
    .dcw_in_addr      (dcw_in_addr),
    .dcw_in_mask      (dcw_in_mask),
    .dcw_in_data      (dcw_in_data),
    .dcw_finish_wresp (dcw_finish_wresp),
    .dcr_start_rq     (dcr_start_rq),
    .dcr_rin_addr     (dcr_rin_addr),
    .rqfull_1         (rqfull_1),
    .rdat_m_data      (rdat_m_data),
    .rdat_m_valid     (rdat_m_valid),
    .finish_mrd       (finish_mrd),
    .bus_err          (bus_err),
    .bus              (bus)
  );

  typedef struct {
    logic [31:0]       addr;
    logic [15:0]       mask;
    logic [127:0]      data;
    logic [31:0]       exp_aw;
    logic [3:0][31:0]  exp_w;
    logic [3:0][3:0]   exp_s;
    int                stall_beat;
    int                stall;
  } wvec_t;

  typedef struct {
    logic [31:0]       addr;
    logic [31:0]       exp_ar;
    logic [3:0][31:0]  beats;
    int                gap;
    int                hold;
    logic [127:0]      exp_line;
  } rvec_t;

  wvec_t wv[2];
  rvec_t rv[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_start(input wvec_t v);
    dcw_in_addr = v.addr;
    dcw_in_mask = v.mask;
    dcw_in_data = v.data;
    dcw_start_rq = 1'b1;
    tick();
    dcw_start_rq = 1'b0;
  endtask

  task automatic run_write(input wvec_t v, input int i,
                           input logic [1:0] br);
    wr_start(v);
    chk($sformatf("w%0d_awvalid", i), bus.awvalid, 1'b1);
    chk($sformatf("w%0d_awaddr", i), bus.awaddr, v.exp_aw);
    chk($sformatf("w%0d_awlen", i), bus.awlen, 8'd3);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == v.stall_beat) begin
        bus.wready = 1'b0;
        repeat (v.stall) begin
          chk($sformatf("w%0d_stall", i), bus.wdata, v.exp_w[k]);
          tick();
        end
        bus.wready = 1'b1;
      end
      chk($sformatf("w%0d_wvalid%0d", i, k), bus.wvalid, 1'b1);
      chk($sformatf("w%0d_wdata%0d", i, k), bus.wdata, v.exp_w[k]);
      chk($sformatf("w%0d_wstrb%0d", i, k), bus.wstrb, v.exp_s[k]);
      chk($sformatf("w%0d_wlast%0d", i, k), bus.wlast, k == 3);
      tick();
    end
    chk($sformatf("w%0d_bready", i), bus.bready, 1'b1);
    chk($sformatf("w%0d_wv_off", i), bus.wvalid, 1'b0);
    chk($sformatf("w%0d_fin_early", i), dcw_finish_wresp, 1'b0);
    bus.bresp = br;
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    bus.bresp = 2'b00;
    chk($sformatf("w%0d_finish", i), dcw_finish_wresp, 1'b1);
    chk($sformatf("w%0d_br_off", i), bus.bready, 1'b0);
    tick();
    chk($sformatf("w%0d_fin_pulse", i), dcw_finish_wresp, 1'b0);
  endtask

  task automatic rd_data(input rvec_t v, input int i);
    for (int k = 0; k < 4; k++) begin
      repeat (v.gap) tick();
      chk($sformatf("r%0d_rready%0d", i, k), bus.rready, 1'b1);
      bus.rvalid = 1'b1;
      bus.rdata = v.beats[k];
      bus.rlast = (k == 3);
      tick();
      bus.rvalid = 1'b0;
      bus.rlast = 1'b0;
    end
    chk($sformatf("r%0d_rr_off", i), bus.rready, 1'b0);
    rqfull_1 = (v.hold > 0);
    for (int h = 0; h < v.hold; h++) begin
      chk($sformatf("r%0d_held", i), rdat_m_valid, 1'b0);
      tick();
    end
    rqfull_1 = 1'b0;
    tick();
    chk($sformatf("r%0d_valid", i), rdat_m_valid, 1'b1);
    chk($sformatf("r%0d_line", i), rdat_m_data, v.exp_line);
    chk($sformatf("r%0d_fin_early", i), finish_mrd, 1'b0);
    tick();
    chk($sformatf("r%0d_v_pulse", i), rdat_m_valid, 1'b0);
    chk($sformatf("r%0d_finish", i), finish_mrd, 1'b1);
    tick();
    chk($sformatf("r%0d_f_pulse", i), finish_mrd, 1'b0);
  endtask

  task automatic run_read(input rvec_t v, input int i);
    dcr_rin_addr = v.addr;
    dcr_start_rq = 1'b1;
    tick();
    dcr_start_rq = 1'b0;
    chk($sformatf("r%0d_arvalid", i), bus.arvalid, 1'b1);
    chk($sformatf("r%0d_araddr", i), bus.araddr, v.exp_ar);
    chk($sformatf("r%0d_arlen", i), bus.arlen, 8'd3);
    tick();
    chk($sformatf("r%0d_ar_off", i), bus.arvalid, 1'b0);
    rd_data(v, i);
  endtask

  initial begin
    wv[0] = '{addr: 32'h0000_1234, mask: 16'h0000,
      data: 128'h44444444_33333333_22222222_11111111,
      exp_aw: 32'h0000_1230,
      exp_w: {32'h44444444, 32'h33333333,
              32'h22222222, 32'h11111111},
      exp_s: {4'hF, 4'hF, 4'hF, 4'hF},
      stall_beat: -1, stall: 0};
    wv[1] = '{addr: 32'hDEAD_BEEF, mask: 16'hF0A5,
      data: 128'h01234567_89ABCDEF_FEDCBA98_76543210,
      exp_aw: 32'hDEAD_BEE0,
      exp_w: {32'h01234567, 32'h89ABCDEF,
              32'hFEDCBA98, 32'h76543210},
      exp_s: {4'h0, 4'hF, 4'h5, 4'hA},
      stall_beat: 2, stall: 5};
    rv[0] = '{addr: 32'h0000_1008, exp_ar: 32'h0000_1000,
      beats: {32'hD, 32'hC, 32'hB, 32'hA},
      gap: 2, hold: 0,
      exp_line: 128'h0000000D_0000000C_0000000B_0000000A};
    rv[1] = '{addr: 32'hFFFF_FFFF, exp_ar: 32'hFFFF_FFF0,
      beats: {32'hFFFFFFFF, 32'h0, 32'h12345678, 32'hCAFEBABE},
      gap: 0, hold: 3,
      exp_line: 128'hFFFFFFFF_00000000_12345678_CAFEBABE};

    bus.awready = 1'b1;
    bus.wready = 1'b1;
    bus.bvalid = 1'b0;
    bus.bresp = 2'b00;
    bus.arready = 1'b1;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    bus.rresp = 2'b00;
    bus.rlast = 1'b0;

    tick();
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.bready,
                       bus.arvalid, bus.rready}, 5'b0);
    chk("rst_pulses", {dcw_finish_wresp, rdat_m_valid,
                       finish_mrd}, 3'b0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_data", rdat_m_data, 128'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 2; i++) run_write(wv[i], i, 2'b00);
    for (int i = 0; i < 2; i++) run_read(rv[i], i);
    repeat (3) tick();
    chk("rdat_hold", rdat_m_data, rv[1].exp_line);
    chk("clean_err", bus_err, 1'b0);

    // Refill requested one cycle behind a write-back.
    wr_start(wv[0]);
    dcr_rin_addr = 32'h8000_0044;
    dcr_start_rq = 1'b1;
    tick();
    dcr_start_rq = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("ord_ar_wait", bus.arvalid, 1'b0);
      tick();
    end
    bus.bvalid = 1'b1;
    chk("ord_ar_wait_b", bus.arvalid, 1'b0);
    tick();
    bus.bvalid = 1'b0;
    chk("ord_wfin", dcw_finish_wresp, 1'b1);
    chk("ord_arvalid", bus.arvalid, 1'b1);
    chk("ord_araddr", bus.araddr, 32'h8000_0040);
    tick();
    rd_data(rv[1], 2);

    // Error response completes normally but latches bus_err.
    run_write(wv[1], 3, 2'b10);
    chk("bresp_err", bus_err, 1'b1);
    repeat (5) tick();
    chk("bresp_sticky", bus_err, 1'b1);

    // Reset in the middle of a write-back.
    wr_start(wv[0]);
    tick();
    chk("mid_wvalid_pre", bus.wvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_async", {bus.awvalid, bus.wvalid,
                          bus.bready, bus_err}, 4'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("mid_no_fin", {dcw_finish_wresp, bus.wvalid}, 2'b0);
      tick();
    end

    // Second write start while busy is dropped.
    bus.awready = 1'b0;
    wr_start(wv[1]);
    dcw_in_data = wv[0].data;
    dcw_in_addr = wv[0].addr;
    dcw_start_rq = 1'b1;
    tick();
    dcw_start_rq = 1'b0;
    chk("busy_err", bus_err, 1'b1);
    chk("busy_awaddr", bus.awaddr, wv[1].exp_aw);
    bus.awready = 1'b1;
    tick();
    chk("busy_wdata", bus.wdata, wv[1].exp_w[0]);
    repeat (4) tick();
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0;
    chk("busy_fin", dcw_finish_wresp, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("busy_no_2nd", bus.awvalid, 1'b0);
      tick();
    end

`ifdef DCBUS_TIMEOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.arready = 1'b0;
    dcr_rin_addr = 32'h0000_2000;
    dcr_start_rq = 1'b1;
    tick();
    dcr_start_rq = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("to_ar_wait", bus.arvalid, 1'b1);
      tick();
    end
    chk("to_ar_drop", bus.arvalid, 1'b0);
    chk("to_err", bus_err, 1'b1);
    tick();
    chk("to_valid", rdat_m_valid, 1'b1);
    chk("to_line", rdat_m_data, 128'h0);
    tick();
    chk("to_finish", finish_mrd, 1'b1);
    bus.arready = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
